// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control FSM.
// MC_CTRL_ADDI_EN: when defined, addi gets its own execute/writeback states.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Encodings are fixed so the addi states leave a hole when compiled out.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
`ifdef MC_CTRL_ADDI_EN
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
`endif
        S_JUMP   = 4'd11
    } state_t;

    // Control word produced from the registered state.
    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       pc_write;
        logic       branch;
    } ctrl_t;

    // Opcodes this controller knows how to sequence.
    function automatic logic op_legal(input logic [5:0] op);
        logic ok;
        ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_J);
`ifdef MC_CTRL_ADDI_EN
        ok = ok || (op == OP_ADDI);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// State to control-word decode for the multicycle controller.
// MC_CTRL_ADDI_EN adds the addi execute/writeback decodes.
module mc_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    // Moore decode; only FETCH folds in mem_ready for the IR/PC update.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = 2'b11;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req   = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b00;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b00;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = 2'b01;
                ctrl.branch    = 1'b1;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
`endif
            S_JUMP: begin
                ctrl.pc_src   = 2'b10;
                ctrl.pc_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath.
// MC_CTRL_ADDI_EN: makes addi a legal opcode with its own two states.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [1:0] alu_op,
    output logic       pc_en,
    output logic       illegal_op
);

    logic [STATE_W-1:0] state_q;
    state_t             st;
    state_t             state_d;
    ctrl_t              c;

    // Only the low bits carry an encoding; the rest stay zero.
    assign st = state_t'(state_q[3:0]);

    // State register; reset lands in FETCH without waiting for an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= STATE_W'(S_FETCH);
        else        state_q <= STATE_W'(state_d);
    end

    // Next-state logic; memory states hold until mem_ready.
    always_comb begin
        state_d = S_FETCH;
        case (st)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEX: state_d = S_ADDIWB;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state     (st),
        .mem_ready (mem_ready),
        .ctrl      (c)
    );

    // Enables are masked while reset is held so FETCH cannot issue anything.
    assign mem_req    = rst_n & c.mem_req;
    assign ir_write   = rst_n & c.ir_write;
    assign mem_write  = rst_n & c.mem_write;
    assign reg_write  = rst_n & c.reg_write;
    assign pc_en      = rst_n & (c.pc_write | (c.branch & zero));
    assign illegal_op = rst_n & (st == S_DECODE) & ~op_legal(op);

    assign iord       = c.iord;
    assign reg_dst    = c.reg_dst;
    assign mem_to_reg = c.mem_to_reg;
    assign alu_src_a  = c.alu_src_a;
    assign alu_src_b  = c.alu_src_b;
    assign pc_src     = c.pc_src;
    assign alu_op     = c.alu_op;

endmodule
